// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - CP0-side TLB maintenance sequencer (TLBR/TLBWI/TLBWR/TLBP)
//
// Owns Index, Random, Wired, EntryHi, EntryLo0 and EntryLo1.
// Sequences TLB maintenance operations against the MMU's read/write and probe ports.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   op_valid, op_type         operation request (00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP)
//   op_ready, op_done         idle indication, one-cycle completion pulse
//   cp0_we/waddr/wdata        CP0 register write port
//   index_reg .. entry_lo1    architectural register values
//   asid                      current ASID to the MMU
//   tlbrw_index/we/wdata      TLB entry select, write strobe and write data
//   tlbrw_rdata               entry read back one cycle after tlbrw_index
//   tlbp_entry_hi, tlbp_index probe key and probe result (bit 31 = miss)

package tlb_op_ctrl_pkg;
   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } TLBEntry_t;
endpackage

module tlb_op_ctrl
   import tlb_op_ctrl_pkg::*;
#(
   parameter int TLB_ENTRIES = 16,
   parameter int INDEX_WIDTH = $clog2(TLB_ENTRIES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   op_valid,
   input  logic [1:0]             op_type,
   output logic                   op_ready,
   output logic                   op_done,
   input  logic                   cp0_we,
   input  logic [2:0]             cp0_waddr,
   input  logic [31:0]            cp0_wdata,
   output logic [31:0]            index_reg,
   output logic [31:0]            random_reg,
   output logic [31:0]            wired_reg,
   output logic [31:0]            entry_hi,
   output logic [31:0]            entry_lo0,
   output logic [31:0]            entry_lo1,
   output logic [7:0]             asid,
   output logic [INDEX_WIDTH-1:0] tlbrw_index,
   output logic                   tlbrw_we,
   output TLBEntry_t              tlbrw_wdata,
   input  TLBEntry_t              tlbrw_rdata,
   output logic [31:0]            tlbp_entry_hi,
   input  logic [31:0]            tlbp_index
);

   localparam logic [1:0] OP_TLBR  = 2'b00;
   localparam logic [1:0] OP_TLBWI = 2'b01;
   localparam logic [1:0] OP_TLBWR = 2'b10;
   localparam logic [1:0] OP_TLBP  = 2'b11;

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(TLB_ENTRIES - 1);
   // TLB_ENTRIES is a power of two, so entries-1 is exactly the index field mask
   localparam logic [31:0] IDX_MASK = 32'(TLB_ENTRIES - 1);
   localparam logic [31:0] HI_MASK  = 32'hFFFF_E0FF;
   localparam logic [31:0] LO_MASK  = 32'h03FF_FFFF;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;

   state_t                 state;
   logic [1:0]             op_q;
   logic [INDEX_WIDTH-1:0] rnd;
   logic [INDEX_WIDTH-1:0] wired_q;

   logic                   idle;
   logic                   wr_index, wr_hi, wr_lo0, wr_lo1, wr_wired;
   logic                   op_is_write;
   logic [INDEX_WIDTH-1:0] idx_now;
   logic                   unused_probe_bits;

   assign idle     = (state == S_IDLE);
   assign op_ready = idle;

   // Register writes other than Wired are only honoured while idle
   assign wr_index = cp0_we && (cp0_waddr == 3'd0) && idle;
   assign wr_hi    = cp0_we && (cp0_waddr == 3'd1) && idle;
   assign wr_lo0   = cp0_we && (cp0_waddr == 3'd2) && idle;
   assign wr_lo1   = cp0_we && (cp0_waddr == 3'd3) && idle;
   assign wr_wired = cp0_we && (cp0_waddr == 3'd4);

   // An Index write in the accept cycle must steer the operation being accepted
   assign idx_now = wr_index ? cp0_wdata[INDEX_WIDTH-1:0] : index_reg[INDEX_WIDTH-1:0];

   assign op_is_write = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);

   assign random_reg    = {{(32-INDEX_WIDTH){1'b0}}, rnd};
   assign wired_reg     = {{(32-INDEX_WIDTH){1'b0}}, wired_q};
   assign asid          = entry_hi[7:0];
   assign tlbp_entry_hi = entry_hi;

   // Registers cannot change while busy, so the packed entry is stable through EXEC
   assign tlbrw_wdata = '{vpn2: entry_hi[31:13],
                          asid: entry_hi[7:0],
                          g:    entry_lo0[0] & entry_lo1[0],
                          pfn0: entry_lo0[25:6],
                          c0:   entry_lo0[5:3],
                          d0:   entry_lo0[2],
                          v0:   entry_lo0[1],
                          pfn1: entry_lo1[25:6],
                          c1:   entry_lo1[5:3],
                          d1:   entry_lo1[2],
                          v1:   entry_lo1[1]};

   assign unused_probe_bits = ^tlbp_index[30:INDEX_WIDTH];

   // Random counter: counts down to Wired, then wraps to the top entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rnd <= LAST_IDX;
      end else if (wr_wired || (wired_q == LAST_IDX) || (rnd == wired_q)) begin
         rnd <= LAST_IDX;
      end else begin
         rnd <= rnd - INDEX_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         op_q        <= OP_TLBR;
         op_done     <= 1'b0;
         tlbrw_we    <= 1'b0;
         tlbrw_index <= '0;
         index_reg   <= '0;
         entry_hi    <= '0;
         entry_lo0   <= '0;
         entry_lo1   <= '0;
         wired_q     <= '0;
      end else begin
         op_done  <= 1'b0;
         tlbrw_we <= 1'b0;

         if (wr_wired) wired_q   <= cp0_wdata[INDEX_WIDTH-1:0];
         if (wr_index) index_reg <= cp0_wdata & IDX_MASK;
         if (wr_hi)    entry_hi  <= cp0_wdata & HI_MASK;
         if (wr_lo0)   entry_lo0 <= cp0_wdata & LO_MASK;
         if (wr_lo1)   entry_lo1 <= cp0_wdata & LO_MASK;

         case (state)
            S_IDLE: begin
               if (op_valid) begin
                  op_q  <= op_type;
                  state <= S_EXEC;
                  // Outputs are registered here so they appear during EXEC
                  case (op_type)
                     OP_TLBWI: begin
                        tlbrw_index <= idx_now;
                        tlbrw_we    <= 1'b1;
                        op_done     <= 1'b1;
                     end
                     OP_TLBWR: begin
                        tlbrw_index <= rnd;
                        tlbrw_we    <= 1'b1;
                        op_done     <= 1'b1;
                     end
                     OP_TLBR: tlbrw_index <= idx_now;
                     default: ;
                  endcase
               end
            end
            S_EXEC: begin
               if (op_is_write) begin
                  state <= S_IDLE;
               end else begin
                  state   <= S_WAIT;
                  op_done <= 1'b1;
               end
            end
            S_WAIT: begin
               if (op_q == OP_TLBR) begin
                  entry_hi  <= {tlbrw_rdata.vpn2, 5'b0, tlbrw_rdata.asid};
                  entry_lo0 <= {6'b0, tlbrw_rdata.pfn0, tlbrw_rdata.c0,
                                tlbrw_rdata.d0, tlbrw_rdata.v0, tlbrw_rdata.g};
                  entry_lo1 <= {6'b0, tlbrw_rdata.pfn1, tlbrw_rdata.c1,
                                tlbrw_rdata.d1, tlbrw_rdata.v1, tlbrw_rdata.g};
               end else if (op_q == OP_TLBP) begin
                  index_reg <= {tlbp_index[31], {(31-INDEX_WIDTH){1'b0}},
                                tlbp_index[INDEX_WIDTH-1:0]};
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
